// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decode-side inputs and the registered EX-side view,
// plus the hazard stall and bubble statistics.
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              i_valid;
  logic              i_flush;
  logic              i_reg_write;
  logic [1:0]        i_result_src;
  logic              i_mem_write;
  logic [2:0]        i_alu_ctl;
  logic              i_alu_src_opb;
  logic              i_branch;
  logic              i_jump;
  logic [REG_AW-1:0] i_rs1_addr;
  logic [REG_AW-1:0] i_rs2_addr;
  logic [REG_AW-1:0] i_rd_addr;
  logic [XLEN-1:0]   i_rs1_data;
  logic [XLEN-1:0]   i_rs2_data;
  logic [XLEN-1:0]   i_imm_ext;
  logic [XLEN-1:0]   i_pc;
  logic [XLEN-1:0]   i_pc_plus4;

  logic              o_valid;
  logic              o_reg_write;
  logic [1:0]        o_result_src;
  logic              o_mem_write;
  logic [2:0]        o_alu_ctl;
  logic              o_alu_src_opb;
  logic              o_branch;
  logic              o_jump;
  logic [REG_AW-1:0] o_rs1_addr;
  logic [REG_AW-1:0] o_rs2_addr;
  logic [REG_AW-1:0] o_rd_addr;
  logic [XLEN-1:0]   o_rs1_data;
  logic [XLEN-1:0]   o_rs2_data;
  logic [XLEN-1:0]   o_imm_ext;
  logic [XLEN-1:0]   o_pc;
  logic [XLEN-1:0]   o_pc_plus4;
  logic              o_stall;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;

  // Decode stage side: presents the instruction and reacts to the stall.
  modport master (
    output i_valid, i_flush, i_reg_write, i_result_src, i_mem_write, i_alu_ctl,
           i_alu_src_opb, i_branch, i_jump, i_rs1_addr, i_rs2_addr, i_rd_addr,
           i_rs1_data, i_rs2_data, i_imm_ext, i_pc, i_pc_plus4,
    input  o_valid, o_reg_write, o_result_src, o_mem_write, o_alu_ctl,
           o_alu_src_opb, o_branch, o_jump, o_rs1_addr, o_rs2_addr, o_rd_addr,
           o_rs1_data, o_rs2_data, o_imm_ext, o_pc, o_pc_plus4,
           o_stall, o_stall_cnt, o_flush_cnt
  );

  // Pipeline register side.
  modport slave (
    input  i_valid, i_flush, i_reg_write, i_result_src, i_mem_write, i_alu_ctl,
           i_alu_src_opb, i_branch, i_jump, i_rs1_addr, i_rs2_addr, i_rd_addr,
           i_rs1_data, i_rs2_data, i_imm_ext, i_pc, i_pc_plus4,
    output o_valid, o_reg_write, o_result_src, o_mem_write, o_alu_ctl,
           o_alu_src_opb, o_branch, o_jump, o_rs1_addr, o_rs2_addr, o_rd_addr,
           o_rs1_data, o_rs2_data, o_imm_ext, o_pc, o_pc_plus4,
           o_stall, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall
// bubble insertion and saturating bubble counters.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic         i_clk,
  input logic         i_rst_n,
  id_ex_pipe_reg_if.slave bus
);

  localparam logic [1:0] RES_MEM = 2'b01;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic [2:0]        alu_ctl;
    logic              alu_src_opb;
    logic              branch;
    logic              jump;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } ex_pkt_t;

  ex_pkt_t          id_pkt;
  ex_pkt_t          ex_d,        ex_q;
  logic             valid_d,     valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             ex_is_load;
  logic             rd_match;
  logic             stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    id_pkt = '{
      reg_write:   bus.i_reg_write,
      result_src:  bus.i_result_src,
      mem_write:   bus.i_mem_write,
      alu_ctl:     bus.i_alu_ctl,
      alu_src_opb: bus.i_alu_src_opb,
      branch:      bus.i_branch,
      jump:        bus.i_jump,
      rs1_addr:    bus.i_rs1_addr,
      rs2_addr:    bus.i_rs2_addr,
      rd_addr:     bus.i_rd_addr,
      rs1_data:    bus.i_rs1_data,
      rs2_data:    bus.i_rs2_data,
      imm_ext:     bus.i_imm_ext,
      pc:          bus.i_pc,
      pc_plus4:    bus.i_pc_plus4
    };
  end

  // rs2 is compared even for I-type sources: a spurious stall costs one
  // cycle, a missed one corrupts data.
  assign ex_is_load = valid_q & ex_q.reg_write & (ex_q.result_src == RES_MEM)
                    & (ex_q.rd_addr != '0);
  assign rd_match   = (ex_q.rd_addr == bus.i_rs1_addr)
                    | (ex_q.rd_addr == bus.i_rs2_addr);
  assign stall      = bus.i_valid & ex_is_load & rd_match;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    ex_d        = id_pkt;
    valid_d     = bus.i_valid;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.i_flush) begin
      ex_d        = '0;
      valid_d     = 1'b0;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (stall) begin
      ex_d        = '0;
      valid_d     = 1'b0;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // NOTE: reset is sampled synchronously here, and state uses non-blocking
  // assignments so every register sees pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_reg_write   = ex_q.reg_write;
  assign bus.o_result_src  = ex_q.result_src;
  assign bus.o_mem_write   = ex_q.mem_write;
  assign bus.o_alu_ctl     = ex_q.alu_ctl;
  assign bus.o_alu_src_opb = ex_q.alu_src_opb;
  assign bus.o_branch      = ex_q.branch;
  assign bus.o_jump        = ex_q.jump;
  assign bus.o_rs1_addr    = ex_q.rs1_addr;
  assign bus.o_rs2_addr    = ex_q.rs2_addr;
  assign bus.o_rd_addr     = ex_q.rd_addr;
  assign bus.o_rs1_data    = ex_q.rs1_data;
  assign bus.o_rs2_data    = ex_q.rs2_data;
  assign bus.o_imm_ext     = ex_q.imm_ext;
  assign bus.o_pc          = ex_q.pc;
  assign bus.o_pc_plus4    = ex_q.pc_plus4;
  assign bus.o_stall       = stall;
  assign bus.o_stall_cnt   = stall_cnt_q;
  assign bus.o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed hazard/flush scenarios then
// random traffic against a transaction-level model; a CNT_W=4 twin checks saturation.
module tb_id_ex_pipe_reg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [2:0]      alu_ctl;
    logic            alu_src_opb;
    logic            branch;
    logic            jump;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } instr_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   drv_valid, drv_flush;
  instr_t drv;

  instr_t exp_pkt;
  logic   exp_valid;
  int     n_stall, n_flush;

  int compared   = 0;
  int mismatched = 0;

  id_ex_pipe_reg_if #(.XLEN(XLEN), .REG_AW(AW), .CNT_W(16)) m_bus ();
  id_ex_pipe_reg_if #(.XLEN(XLEN), .REG_AW(AW), .CNT_W(4))  s_bus ();

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(AW), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(m_bus.slave));
  id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(AW), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .bus(s_bus.slave));

  always #5 clk = ~clk;

  assign m_bus.i_valid = drv_valid;       assign s_bus.i_valid = drv_valid;
  assign m_bus.i_flush = drv_flush;       assign s_bus.i_flush = drv_flush;
  assign m_bus.i_reg_write = drv.reg_write;     assign s_bus.i_reg_write = drv.reg_write;
  assign m_bus.i_result_src = drv.result_src;   assign s_bus.i_result_src = drv.result_src;
  assign m_bus.i_mem_write = drv.mem_write;     assign s_bus.i_mem_write = drv.mem_write;
  assign m_bus.i_alu_ctl = drv.alu_ctl;         assign s_bus.i_alu_ctl = drv.alu_ctl;
  assign m_bus.i_alu_src_opb = drv.alu_src_opb; assign s_bus.i_alu_src_opb = drv.alu_src_opb;
  assign m_bus.i_branch = drv.branch;           assign s_bus.i_branch = drv.branch;
  assign m_bus.i_jump = drv.jump;               assign s_bus.i_jump = drv.jump;
  assign m_bus.i_rs1_addr = drv.rs1;            assign s_bus.i_rs1_addr = drv.rs1;
  assign m_bus.i_rs2_addr = drv.rs2;            assign s_bus.i_rs2_addr = drv.rs2;
  assign m_bus.i_rd_addr = drv.rd;              assign s_bus.i_rd_addr = drv.rd;
  assign m_bus.i_rs1_data = drv.rs1_data;       assign s_bus.i_rs1_data = drv.rs1_data;
  assign m_bus.i_rs2_data = drv.rs2_data;       assign s_bus.i_rs2_data = drv.rs2_data;
  assign m_bus.i_imm_ext = drv.imm;             assign s_bus.i_imm_ext = drv.imm;
  assign m_bus.i_pc = drv.pc;                   assign s_bus.i_pc = drv.pc;
  assign m_bus.i_pc_plus4 = drv.pc4;            assign s_bus.i_pc_plus4 = drv.pc4;

  instr_t obs_pkt;
  assign obs_pkt = {m_bus.o_reg_write, m_bus.o_result_src, m_bus.o_mem_write,
                    m_bus.o_alu_ctl, m_bus.o_alu_src_opb, m_bus.o_branch, m_bus.o_jump,
                    m_bus.o_rs1_addr, m_bus.o_rs2_addr, m_bus.o_rd_addr,
                    m_bus.o_rs1_data, m_bus.o_rs2_data, m_bus.o_imm_ext,
                    m_bus.o_pc, m_bus.o_pc_plus4};

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A load in EX feeding a source of the valid ID instruction, unless it targets x0.
  function automatic logic model_stall();
    return drv_valid && exp_valid && exp_pkt.reg_write && exp_pkt.result_src == 2'b01
        && exp_pkt.rd != 0 && (exp_pkt.rd == drv.rs1 || exp_pkt.rd == drv.rs2);
  endfunction

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  // Check the combinational stall, clock once, advance the model, check state.
  task automatic step(input string tag);
    logic st;
    #1;
    st = model_stall();
    check({tag, ".stall"}, 192'(m_bus.o_stall), 192'(st));
    check({tag, ".stall_sat"}, 192'(s_bus.o_stall), 192'(st));
    @(posedge clk);
    if (!rst_n) begin
      exp_pkt = '0; exp_valid = 1'b0; n_stall = 0; n_flush = 0;
    end else if (drv_flush) begin
      exp_pkt = '0; exp_valid = 1'b0; n_flush++;
    end else if (st) begin
      exp_pkt = '0; exp_valid = 1'b0; n_stall++;
    end else begin
      exp_pkt = drv; exp_valid = drv_valid;
    end
    #1;
    check({tag, ".fields"}, 192'(obs_pkt), 192'(exp_pkt));
    check({tag, ".valid"}, 192'(m_bus.o_valid), 192'(exp_valid));
    check({tag, ".stall_cnt"}, 192'(m_bus.o_stall_cnt), 192'(sat(n_stall, 16)));
    check({tag, ".flush_cnt"}, 192'(m_bus.o_flush_cnt), 192'(sat(n_flush, 16)));
    check({tag, ".sat_stall_cnt"}, 192'(s_bus.o_stall_cnt), 192'(sat(n_stall, 4)));
    check({tag, ".sat_flush_cnt"}, 192'(s_bus.o_flush_cnt), 192'(sat(n_flush, 4)));
  endtask

  task automatic randomize_drv(input int addr_max);
    drv.reg_write   = 1'($urandom);
    drv.result_src  = 2'($urandom_range(0, 2));
    drv.mem_write   = 1'($urandom);
    drv.alu_ctl     = 3'($urandom);
    drv.alu_src_opb = 1'($urandom);
    drv.branch      = 1'($urandom);
    drv.jump        = 1'($urandom);
    drv.rs1         = AW'($urandom_range(0, addr_max));
    drv.rs2         = AW'($urandom_range(0, addr_max));
    drv.rd          = AW'($urandom_range(0, addr_max));
    drv.rs1_data    = $urandom;
    drv.rs2_data    = $urandom;
    drv.imm         = $urandom;
    drv.pc          = $urandom;
    drv.pc4         = $urandom;
  endtask

  function automatic instr_t mk(input logic rw, input logic [1:0] rs, input int rs1,
                                input int rs2, input int rd, input logic [31:0] pc);
    instr_t t;
    t = '0;
    t.reg_write = rw; t.result_src = rs; t.alu_src_opb = (rs == 2'b01);
    t.rs1 = AW'(rs1); t.rs2 = AW'(rs2); t.rd = AW'(rd);
    t.rs1_data = 32'h1000 + pc; t.rs2_data = 32'h2000 + pc;
    t.pc = pc; t.pc4 = pc + 32'd4;
    return t;
  endfunction

  initial begin
    exp_pkt = '0; exp_valid = 1'b0; n_stall = 0; n_flush = 0;
    rst_n = 1'b0; drv_flush = 1'b0; drv_valid = 1'b0; drv = '0;
    @(posedge clk); #1;

    // Reset with random inputs, including flush, must still give all zeros.
    for (int i = 0; i < 2; i++) begin
      randomize_drv(31); drv_valid = 1'($urandom); drv_flush = 1'($urandom);
      step("reset");
    end
    rst_n = 1'b1; drv_flush = 1'b0;

    // addi x5,x1,12 at pc 0x40
    drv = '0; drv_valid = 1'b1;
    drv.reg_write = 1'b1; drv.alu_src_opb = 1'b1; drv.rs1 = 5'd1; drv.rd = 5'd5;
    drv.imm = 32'd12; drv.rs1_data = 32'h77; drv.pc = 32'h40; drv.pc4 = 32'h44;
    step("addi");

    // lw x6 then add x7,x6,x2: stall, bubble, then the add is latched.
    drv = mk(1'b1, 2'b01, 1, 0, 6, 32'h44);  step("lw_x6");
    drv = mk(1'b1, 2'b00, 6, 2, 7, 32'h48);  step("loaduse_stall");
    step("loaduse_release");

    // Load into x0 never stalls; neither does an ALU producer.
    drv = mk(1'b1, 2'b01, 3, 0, 0, 32'h4c);  step("lw_x0");
    drv = mk(1'b1, 2'b00, 0, 0, 8, 32'h50);  step("use_x0");
    drv = mk(1'b1, 2'b00, 2, 3, 9, 32'h54);  step("alu_x9");
    drv = mk(1'b1, 2'b00, 9, 9, 10, 32'h58); step("use_alu");

    // Flush coincident with a load-use hazard: one bubble, flush counter only.
    drv = mk(1'b1, 2'b01, 1, 0, 6, 32'h5c);  step("lw_x6_b");
    drv = mk(1'b1, 2'b00, 6, 2, 7, 32'h60);  drv_flush = 1'b1; step("flush_hazard");
    drv_flush = 1'b0;

    // 20 more stall bubbles: the 4-bit twin saturates at 15.
    for (int i = 0; i < 20; i++) begin
      drv = mk(1'b1, 2'b01, 1, 0, 6, 32'h100 + 32'(8 * i)); step("sat_lw");
      drv = mk(1'b1, 2'b00, 2, 6, 7, 32'h104 + 32'(8 * i)); step("sat_use");
    end

    // Reset mid-run clears the counters on the following edge.
    rst_n = 1'b0; step("mid_reset");
    rst_n = 1'b1;

    // Random traffic with a narrow register space to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      randomize_drv(3);
      drv_valid = ($urandom_range(0, 9) != 0);
      drv_flush = ($urandom_range(0, 7) == 0);
      rst_n     = ($urandom_range(0, 59) != 0);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
